// File: rtl/t05_decode_byte_packer_pkg.sv
// Shared types and constants for the decode byte packer.
package t05_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {PK_IDLE, PK_PACK, PK_FLUSH, PK_DONE} packer_state_t;

endpackage

// File: rtl/t05_decode_byte_packer_if.sv
// Bit-stream input and byte-stream output handshakes of the packer.
interface t05_decode_byte_packer_if;
   import t05_pkg::*;

   logic              bit_in;
   logic              bit_valid;
   logic              bit_ready;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_ready;

   modport master (
      output bit_in, bit_valid, byte_ready,
      input  bit_ready, byte_out, byte_valid
   );

   modport slave (
      input  bit_in, bit_valid, byte_ready,
      output bit_ready, byte_out, byte_valid
   );

endinterface

// File: rtl/t05_decode_byte_packer_fifo.sv
// Byte FIFO with extra-MSB pointers; head byte is read straight from the register array.
module t05_byte_fifo
   import t05_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] wdata,
   output logic [BYTE_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_q;
   logic [AW:0]       rd_q;
   logic              push_ok;
   logic              pop_ok;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rdata   = mem_q[rd_q[AW-1:0]];
   // A push into a full FIFO is fine when the head leaves on the same edge.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q[AW-1:0]] <= wdata;
            wr_q                <= wr_q + 1'b1;
         end
         if (pop_ok) rd_q <= rd_q + 1'b1;
      end
   end

endmodule

// File: rtl/t05_decode_byte_packer.sv
// Packs MSB-first decoded bits into bytes, buffers them and reports drain completion.
//
// state    | meaning
// PK_IDLE  | waiting for pack_enable
// PK_PACK  | shifting bits in, pushing completed bytes
// PK_FLUSH | no more bits; draining the FIFO
// PK_DONE  | everything drained, done held until reset
module t05_decode_byte_packer
   import t05_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pack_enable_i,
   input  logic                     src_finished_i,
   t05_decode_byte_packer_if.slave  bus,
   output logic [CNT_W-1:0]         bytes_written_o,
   output logic                     align_error_o,
   output logic                     done_o
);

   packer_state_t     state_q, state_d;
   logic [BYTE_W-1:0] sr_q, sr_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              align_q, align_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              full;
   logic              empty;
   logic              bit_acc;
   logic              push;
   logic              pop;

   assign bus.bit_ready  = pack_enable_i && (state_q == PK_PACK)
                           && !((bit_cnt_q == 3'd7) && full && !bus.byte_ready);
   assign bit_acc        = bus.bit_valid && bus.bit_ready;
   assign push           = bit_acc && (bit_cnt_q == 3'd7);
   assign pop            = pack_enable_i && !empty && bus.byte_ready;
   assign bus.byte_valid = !empty;

   t05_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({sr_q[BYTE_W-2:0], bus.bit_in}),
      .rdata (bus.byte_out),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      align_d   = align_q;
      cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, pop};

      if (bit_acc) begin
         sr_d      = {sr_q[BYTE_W-2:0], bus.bit_in};
         bit_cnt_d = bit_cnt_q + 3'd1;
      end

      case (state_q)
         PK_IDLE:  if (pack_enable_i) state_d = PK_PACK;
         PK_PACK: begin
            // A bit arriving with src_finished is taken first; the exit waits a cycle.
            if (pack_enable_i && src_finished_i && !bit_acc) begin
               state_d = PK_FLUSH;
               if (bit_cnt_q != 3'd0) begin
                  align_d   = 1'b1;
                  bit_cnt_d = 3'd0;
                  sr_d      = '0;
               end
            end
         end
         PK_FLUSH: if (pack_enable_i && empty) state_d = PK_DONE;
         default:  state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= PK_IDLE;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         align_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         align_q   <= align_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bytes_written_o = cnt_q;
   assign align_error_o   = align_q;
   assign done_o          = (state_q == PK_DONE);

endmodule

// File: tb/tb_t05_decode_byte_packer.sv
// Directed bench for the byte packer: a per-cycle vector table plus scripted corner sequences.
module tb_t05_decode_byte_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pack_enable = 1'b0;
   logic        src_finished = 1'b0;
   logic [31:0] bytes_written;
   logic        align_error;
   logic        done;

   int n_vec  = 0;
   int n_fail = 0;

   t05_decode_byte_packer_if bus_if ();

   t05_decode_byte_packer #(.DEPTH(4), .CNT_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .pack_enable_i   (pack_enable),
      .src_finished_i  (src_finished),
      .bus             (bus_if),
      .bytes_written_o (bytes_written),
      .align_error_o   (align_error),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   // flags = {en, bit_valid, bit_in, byte_ready, src_finished, exp_bit_ready, exp_byte_valid, check_byte_out}
   typedef struct {
      logic [7:0] flags;
      logic [7:0] x_out;
      logic [7:0] x_bw;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic [7:0] flags, input logic [7:0] x_out, input logic [7:0] x_bw);
      vec_t v;
      v.flags = flags;
      v.x_out = x_out;
      v.x_bw  = x_bw;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 unit later, well before the rising edge.
   task automatic drive(input logic en, input logic bv, input logic bi, input logic br, input logic sf);
      @(negedge clk);
      pack_enable       = en;
      bus_if.bit_valid  = bv;
      bus_if.bit_in     = bi;
      bus_if.byte_ready = br;
      src_finished      = sf;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst               = 1'b0;
      pack_enable       = 1'b0;
      bus_if.bit_valid  = 1'b0;
      bus_if.bit_in     = 1'b0;
      bus_if.byte_ready = 1'b0;
      src_finished      = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic br, input string nm);
      for (int j = 7; j >= 0; j--) begin
         drive(1'b1, 1'b1, b[j], br, 1'b0);
         chk(nm, 32'(bus_if.bit_ready), 32'd1);
      end
   endtask

   initial begin
      logic [7:0] b41;
      logic [7:0] b42;
      logic [7:0] bp [5];
      logic [7:0] tail;

      bus_if.bit_in     = 1'b0;
      bus_if.bit_valid  = 1'b0;
      bus_if.byte_ready = 1'b0;

      // ---- vector table: 0x41, 0x42 streamed with byte_ready high ----
      b41 = 8'h41;
      b42 = 8'h42;
      tbl[0] = mk(8'b0_0_0_0_0_0_0_1, 8'h00, 8'd0);
      tbl[1] = mk(8'b1_0_0_0_0_0_0_0, 8'h00, 8'd0);
      for (int k = 0; k < 8; k++)
         tbl[2+k] = mk({1'b1, 1'b1, b41[7-k], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 8'h00, 8'd0);
      tbl[10] = mk({1'b1, 1'b1, b42[7], 1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, 8'h41, 8'd0);
      for (int k = 1; k < 8; k++)
         tbl[10+k] = mk({1'b1, 1'b1, b42[7-k], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, 8'h00, 8'd1);
      tbl[18] = mk(8'b1_0_0_1_0_1_1_1, 8'h42, 8'd1);
      tbl[19] = mk(8'b1_0_0_0_0_1_0_0, 8'h00, 8'd2);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].flags[7], tbl[i].flags[6], tbl[i].flags[5], tbl[i].flags[4], tbl[i].flags[3]);
         chk($sformatf("tbl%0d_bit_ready", i), 32'(bus_if.bit_ready), 32'(tbl[i].flags[2]));
         chk($sformatf("tbl%0d_byte_valid", i), 32'(bus_if.byte_valid), 32'(tbl[i].flags[1]));
         if (tbl[i].flags[0])
            chk($sformatf("tbl%0d_byte_out", i), 32'(bus_if.byte_out), 32'(tbl[i].x_out));
         chk($sformatf("tbl%0d_bytes_written", i), bytes_written, 32'(tbl[i].x_bw));
         chk($sformatf("tbl%0d_align", i), 32'(align_error), 32'd0);
      end

      // ---- backpressure: 40 bits with byte_ready low, then simultaneous push/pop on full ----
      bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33; bp[3] = 8'h44; bp[4] = 8'h55;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 39; i++) begin
         drive(1'b1, 1'b1, bp[i/8][7-(i%8)], 1'b0, 1'b0);
         chk("bp_accept", 32'(bus_if.bit_ready), 32'd1);
      end
      drive(1'b1, 1'b1, bp[4][0], 1'b0, 1'b0);
      chk("bp_stall_ready", 32'(bus_if.bit_ready), 32'd0);
      chk("bp_stall_out", 32'(bus_if.byte_out), 32'h11);
      drive(1'b1, 1'b1, bp[4][0], 1'b0, 1'b0);
      chk("bp_stall2_ready", 32'(bus_if.bit_ready), 32'd0);
      chk("bp_stall2_out", 32'(bus_if.byte_out), 32'h11);
      chk("bp_stall2_valid", 32'(bus_if.byte_valid), 32'd1);
      drive(1'b1, 1'b1, bp[4][0], 1'b1, 1'b0);
      chk("full_pushpop_ready", 32'(bus_if.bit_ready), 32'd1);
      chk("full_pushpop_out", 32'(bus_if.byte_out), 32'h11);
      for (int k = 1; k < 5; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("drain%0d_valid", k), 32'(bus_if.byte_valid), 32'd1);
         chk($sformatf("drain%0d_out", k), 32'(bus_if.byte_out), 32'(bp[k]));
         chk($sformatf("drain%0d_bw", k), bytes_written, 32'(k));
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("drain_empty", 32'(bus_if.byte_valid), 32'd0);
      chk("drain_bw", bytes_written, 32'd5);

      // ---- 3 aligned bytes buffered, then src_finished and flush ----
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'hA1, 1'b0, "fl_bit");
      send_byte(8'hB2, 1'b0, "fl_bit");
      send_byte(8'hC3, 1'b0, "fl_bit");
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("fl_pack_done", 32'(done), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_no_bits", 32'(bus_if.bit_ready), 32'd0);
      chk("fl_out0", 32'(bus_if.byte_out), 32'hA1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_out1", 32'(bus_if.byte_out), 32'hB2);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_out2", 32'(bus_if.byte_out), 32'hC3);
      chk("fl_done_before", 32'(done), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_empty", 32'(bus_if.byte_valid), 32'd0);
      chk("fl_done_early", 32'(done), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fl_done", 32'(done), 32'd1);
      chk("fl_align", 32'(align_error), 32'd0);
      chk("fl_bw", bytes_written, 32'd3);

      // ---- 13 bits then src_finished: partial byte dropped ----
      tail = 8'b1011_0000;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send_byte(8'h5A, 1'b1, "al_bit");
      for (int j = 7; j >= 3; j--) begin
         drive(1'b1, 1'b1, tail[j], 1'b1, 1'b0);
         if (j == 7) chk("al_out", 32'(bus_if.byte_out), 32'h5A);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("al_pre_align", 32'(align_error), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("al_align", 32'(align_error), 32'd1);
      chk("al_empty", 32'(bus_if.byte_valid), 32'd0);
      chk("al_flush_ready", 32'(bus_if.bit_ready), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("al_done", 32'(done), 32'd1);
      chk("al_bw", bytes_written, 32'd1);
      chk("al_align_sticky", 32'(align_error), 32'd1);

      // ---- reset mid-operation, then a clean 0xA5 ----
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'h01, 1'b0, "rs_bit");
      send_byte(8'h02, 1'b0, "rs_bit");
      send_byte(8'h03, 1'b0, "rs_bit");
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 5; j++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rs_pre_bw", bytes_written, 32'd1);
      chk("rs_pre_valid", 32'(bus_if.byte_valid), 32'd1);
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rs_valid", 32'(bus_if.byte_valid), 32'd0);
      chk("rs_bw", bytes_written, 32'd0);
      chk("rs_out", 32'(bus_if.byte_out), 32'h00);
      chk("rs_ready", 32'(bus_if.bit_ready), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_byte(8'hA5, 1'b0, "rs_a5_bit");
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("rs_a5_valid", 32'(bus_if.byte_valid), 32'd1);
      chk("rs_a5_out", 32'(bus_if.byte_out), 32'hA5);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rs_a5_empty", 32'(bus_if.byte_valid), 32'd0);
      chk("rs_a5_bw", bytes_written, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
